projectile_pool: RTL and testbench

- Parametrised pool of N projectile slots with position tracking. Generalises the fixed player and enemy bullet arrays in the game top.
- Allocates shots on request, advances every live slot once per frame tick, retires slots that leave the playfield, and clears slots reported hit by the collision logic.
- Instantiated once for player shots (DIR=0) and once per enemy bullet group (DIR=1).

---
 rtl/projectile_pool.sv | 246 ++++++++++++++++++++++++
 tb/tb_projectile_pool.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/projectile_pool.sv
// Pool of NUM_SLOTS projectiles: allocates on fire, sweeps one slot per cycle on each tick,
// retires out-of-bounds shots, clears hit slots. Optional counters under PROJECTILE_POOL_STATS_EN.
module projectile_pool #(
  parameter int NUM_SLOTS = 8,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int SPEED     = 4,
  parameter int DIR       = 0,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int COOLDOWN  = 8
) (
  input  logic                                 i_Clk,
  input  logic                                 i_Rst,
  input  logic                                 i_Tick,
  input  logic                                 i_Clear,
  input  logic                                 i_Fire,
  input  logic [X_W-1:0]                       i_FireX,
  input  logic [Y_W-1:0]                       i_FireY,
  input  logic                                 i_HitValid,
  input  logic [$clog2(NUM_SLOTS)-1:0]         i_HitIdx,
  output logic                                 o_FireAck,
  output logic [NUM_SLOTS-1:0]                 o_Active,
  output logic [NUM_SLOTS*(X_W+Y_W)-1:0]       o_PosFlat,
  output logic [$clog2(NUM_SLOTS+1)-1:0]       o_Count,
  output logic                                 o_Busy,
  output logic                                 o_Overrun
`ifdef PROJECTILE_POOL_STATS_EN
  ,
  output logic [15:0]                          o_ShotsFired,
  output logic [15:0]                          o_ShotsExpired
`endif
);

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int P_W   = X_W + Y_W;
  localparam int CD_W  = $clog2(COOLDOWN + 2);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [P_W-1:0]       pos_q [NUM_SLOTS];
  logic [P_W-1:0]       pos_d [NUM_SLOTS];
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic                 overrun_q, overrun_d;

  logic                 free_any;
  logic [IDX_W-1:0]     free_idx;
  logic [CNT_W-1:0]     ones;
  logic                 fire_ok;
  logic                 hit_ok;
  logic                 hit_on_swept;
  logic                 sweep_live;
  logic [Y_W-1:0]       y_cur;
  logic [Y_W:0]         y_wide;
  logic [Y_W-1:0]       y_next;
  logic                 retire;

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!active_q[k]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    ones = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      ones = ones + CNT_W'(active_q[k]);
    end
  end

  assign y_cur  = pos_q[idx_q][Y_W-1:0];
  assign y_wide = {1'b0, y_cur};

  // Bounds checks are done one bit wider than Y so a shot near the edge retires instead of wrapping.
  generate
    if (DIR == 0) begin : g_up
      localparam logic [Y_W:0] LOW_LIM = (Y_W + 1)'(Y_MIN + SPEED);
      assign retire = y_wide < LOW_LIM;
      assign y_next = y_cur - Y_W'(SPEED);
    end else begin : g_down
      localparam logic [Y_W:0] HIGH_LIM = (Y_W + 1)'(Y_MAX);
      localparam logic [Y_W:0] STEP     = (Y_W + 1)'(SPEED);
      logic [Y_W:0] y_sum;
      assign y_sum  = y_wide + STEP;
      assign retire = y_sum > HIGH_LIM;
      assign y_next = y_sum[Y_W-1:0];
    end
  endgenerate

  assign sweep_live   = (state_q == S_SWEEP) && active_q[idx_q];
  assign hit_ok       = i_HitValid && (32'(i_HitIdx) < NUM_SLOTS);
  assign hit_on_swept = hit_ok && (state_q == S_SWEEP) && (i_HitIdx == idx_q);
  assign fire_ok      = i_Fire && (state_q == S_IDLE) && !i_Tick && (cd_q == '0)
                        && free_any && !i_Clear;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    active_d  = active_q;
    pos_d     = pos_q;
    cd_d      = cd_q;
    overrun_d = overrun_q;
    count_d   = ones;

    if (i_Tick && (cd_q != '0)) begin
      cd_d = cd_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_Tick) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        if (i_Tick) begin
          overrun_d = 1'b1;
        end
        if (32'(idx_q) == NUM_SLOTS - 1) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        if (sweep_live && !hit_on_swept) begin
          if (retire) begin
            active_d[idx_q] = 1'b0;
          end else begin
            pos_d[idx_q][Y_W-1:0] = y_next;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    if (hit_ok) begin
      active_d[i_HitIdx] = 1'b0;
    end

    // A fire only targets a slot that is already free, so a stale hit on it must not undo the spawn.
    if (fire_ok) begin
      active_d[free_idx] = 1'b1;
      pos_d[free_idx]    = {i_FireX, i_FireY};
      cd_d               = CD_W'(COOLDOWN);
    end

    if (i_Clear) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      active_d  = '0;
      pos_d     = pos_q;
      cd_d      = '0;
      overrun_d = 1'b0;
      count_d   = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      active_q  <= '0;
      count_q   <= '0;
      cd_q      <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        pos_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      count_q   <= count_d;
      cd_q      <= cd_d;
      overrun_q <= overrun_d;
      pos_q     <= pos_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
      assign o_PosFlat[g*P_W +: P_W] = pos_q[g];
    end
  endgenerate

  assign o_FireAck = fire_ok;
  assign o_Active  = active_q;
  assign o_Count   = count_q;
  assign o_Busy    = (state_q == S_SWEEP);
  assign o_Overrun = overrun_q;

`ifdef PROJECTILE_POOL_STATS_EN
  logic [15:0] fired_q, fired_d;
  logic [15:0] expired_q, expired_d;
  logic        expire;

  // Hits are not expiries: a retirement suppressed by a same-cycle hit is not counted.
  always_comb begin
    expire    = sweep_live && retire && !hit_on_swept;
    fired_d   = fired_q;
    expired_d = expired_q;
    if (fire_ok && (fired_q != 16'hFFFF)) begin
      fired_d = fired_q + 16'd1;
    end
    if (expire && (expired_q != 16'hFFFF)) begin
      expired_d = expired_q + 16'd1;
    end
    if (i_Clear) begin
      fired_d   = '0;
      expired_d = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      fired_q   <= '0;
      expired_q <= '0;
    end else begin
      fired_q   <= fired_d;
      expired_q <= expired_d;
    end
  end

  assign o_ShotsFired   = fired_q;
  assign o_ShotsExpired = expired_q;
`endif

endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: DUT A (DIR=0, COOLDOWN=8) and DUT B (DIR=1, COOLDOWN=0)
// share stimulus; each scenario checks one of them against a slot-array model.
module tb_projectile_pool;
  localparam int N   = 8;
  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int PW  = XW + YW;
  localparam int SPD = 4;

  logic clk = 1'b0;
  logic rst, tick, clr, fire, hit_v;
  logic [XW-1:0] fx;
  logic [YW-1:0] fy;
  logic [2:0]    hit_idx;

  logic          a_ack, b_ack, a_busy, b_busy, a_ovr, b_ovr;
  logic [N-1:0]  a_act, b_act;
  logic [N*PW-1:0] a_pos, b_pos;
  logic [3:0]    a_cnt, b_cnt;
`ifdef PROJECTILE_POOL_STATS_EN
  logic [15:0]   a_sf, a_se, b_sf, b_se;
`endif

  int sel;
  logic          c_ack, c_busy, c_ovr;
  logic [N-1:0]  c_act;
  logic [N*PW-1:0] c_pos;
  logic [3:0]    c_cnt;
  assign c_ack  = (sel != 0) ? b_ack  : a_ack;
  assign c_busy = (sel != 0) ? b_busy : a_busy;
  assign c_ovr  = (sel != 0) ? b_ovr  : a_ovr;
  assign c_act  = (sel != 0) ? b_act  : a_act;
  assign c_pos  = (sel != 0) ? b_pos  : a_pos;
  assign c_cnt  = (sel != 0) ? b_cnt  : a_cnt;

  always #5 clk = ~clk;

  projectile_pool #(.NUM_SLOTS(N), .DIR(0), .COOLDOWN(8)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Tick(tick), .i_Clear(clr), .i_Fire(fire),
    .i_FireX(fx), .i_FireY(fy), .i_HitValid(hit_v), .i_HitIdx(hit_idx),
    .o_FireAck(a_ack), .o_Active(a_act), .o_PosFlat(a_pos), .o_Count(a_cnt),
    .o_Busy(a_busy), .o_Overrun(a_ovr)
`ifdef PROJECTILE_POOL_STATS_EN
    , .o_ShotsFired(a_sf), .o_ShotsExpired(a_se)
`endif
  );

  projectile_pool #(.NUM_SLOTS(N), .DIR(1), .COOLDOWN(0)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Tick(tick), .i_Clear(clr), .i_Fire(fire),
    .i_FireX(fx), .i_FireY(fy), .i_HitValid(hit_v), .i_HitIdx(hit_idx),
    .o_FireAck(b_ack), .o_Active(b_act), .o_PosFlat(b_pos), .o_Count(b_cnt),
    .o_Busy(b_busy), .o_Overrun(b_ovr)
`ifdef PROJECTILE_POOL_STATS_EN
    , .o_ShotsFired(b_sf), .o_ShotsExpired(b_se)
`endif
  );

  int checks = 0;
  int failures = 0;
  int acks;

  // Reference model: one entry per slot, moved a whole tick at a time.
  bit m_act [N];
  int m_x [N];
  int m_y [N];
  int m_cd, m_dir, m_cool;

  function automatic void m_reset(input int dir, input int cool);
    for (int k = 0; k < N; k++) begin
      m_act[k] = 0; m_x[k] = 0; m_y[k] = 0;
    end
    m_cd = 0; m_dir = dir; m_cool = cool;
  endfunction

  function automatic int m_free();
    for (int k = 0; k < N; k++) if (!m_act[k]) return k;
    return -1;
  endfunction

  function automatic bit m_fire(input int x, input int y);
    int f;
    f = m_free();
    if (m_cd != 0 || f < 0) return 0;
    m_act[f] = 1; m_x[f] = x; m_y[f] = y; m_cd = m_cool;
    return 1;
  endfunction

  function automatic void m_tick();
    for (int k = 0; k < N; k++) begin
      if (m_act[k]) begin
        if (m_dir == 0) begin
          if (m_y[k] < 0 + SPD) m_act[k] = 0; else m_y[k] = m_y[k] - SPD;
        end else begin
          if (m_y[k] + SPD > 479) m_act[k] = 0; else m_y[k] = m_y[k] + SPD;
        end
      end
    end
    if (m_cd > 0) m_cd = m_cd - 1;
  endfunction

  function automatic logic [N-1:0] m_act_vec();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_act[k];
    return v;
  endfunction

  function automatic logic [N*PW-1:0] m_pos_vec();
    logic [N*PW-1:0] v;
    for (int k = 0; k < N; k++) v[k*PW +: PW] = {XW'(m_x[k]), YW'(m_y[k])};
    return v;
  endfunction

  function automatic logic [3:0] m_count();
    int c;
    c = 0;
    for (int k = 0; k < N; k++) if (m_act[k]) c++;
    return 4'(c);
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset(input int dir, input int cool);
    rst = 1; tick = 0; clr = 0; fire = 0; hit_v = 0; fx = '0; fy = '0; hit_idx = '0;
    cyc();
    rst = 0;
    m_reset(dir, cool);
  endtask

  task automatic fire_once(input int budget, input int x, input int y, output bit acked);
    fire = 1; fx = XW'(x); fy = YW'(y); acked = 0;
    for (int i = 0; i < budget; i++) begin
      #3;
      if (c_ack) acked = 1;
      cyc();
      if (acked) break;
    end
    fire = 0;
  endtask

  task automatic do_tick(output int busy_len);
    tick = 1; cyc(); tick = 0;
    busy_len = 0;
    while (c_busy && busy_len < 40) begin
      busy_len++;
      cyc();
    end
  endtask

  task automatic do_hit(input int idx);
    hit_v = 1; hit_idx = 3'(idx); cyc(); hit_v = 0;
    m_act[idx] = 0;
  endtask

  task automatic run_cycle();
    #3;
    if (c_ack) begin
      acks++;
      void'(m_fire(fx, fy));
    end
    cyc();
  endtask

  task automatic test_reset();
    sel = 0;
    apply_reset(0, 8);
    checks++; if (c_act !== '0) begin failures++; $display("FAIL reset_active got=%0h exp=0", c_act); end
    checks++; if (c_pos !== '0) begin failures++; $display("FAIL reset_pos got=%0h exp=0", c_pos); end
    checks++; if (c_cnt !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", c_cnt); end
    checks++; if (c_busy !== 1'b0 || c_ovr !== 1'b0 || c_ack !== 1'b0) begin
      failures++; $display("FAIL reset_flags got busy=%b ovr=%b ack=%b exp=000", c_busy, c_ovr, c_ack);
    end
  endtask

  task automatic test_basic_fire();
    bit acked;
    int bl;
    fire_once(1, 320, 400, acked);
    checks++; if (acked !== 1'b1) begin failures++; $display("FAIL basic_ack got=%b exp=1", acked); end
    void'(m_fire(320, 400));
    checks++; if (c_act !== 8'h01) begin failures++; $display("FAIL basic_active got=%0h exp=01", c_act); end
    checks++; if (c_pos !== m_pos_vec()) begin failures++; $display("FAIL basic_pos got=%0h exp=%0h", c_pos, m_pos_vec()); end
    do_tick(bl);
    m_tick();
    checks++; if (bl != N) begin failures++; $display("FAIL basic_sweep_len got=%0d exp=%0d", bl, N); end
    checks++; if (c_pos[YW-1:0] !== 9'd396) begin failures++; $display("FAIL basic_y_moved got=%0d exp=396", c_pos[YW-1:0]); end
    checks++; if (c_cnt !== 4'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", c_cnt); end
  endtask

  task automatic test_cooldown();
    sel = 0;
    apply_reset(0, 8);
    fire = 1; fx = 10'd50; fy = 9'd300; acks = 0;
    for (int i = 0; i < 3; i++) run_cycle();
    for (int t = 1; t <= 8; t++) begin
      tick = 1; run_cycle(); tick = 0;
      m_tick();
      for (int i = 0; i < 10; i++) run_cycle();
      if (t == 3 || t == 7) begin
        checks++; if (acks != 1) begin failures++; $display("FAIL cooldown_hold_t%0d got=%0d exp=1", t, acks); end
      end
    end
    checks++; if (acks != 2) begin failures++; $display("FAIL cooldown_second_ack got=%0d exp=2", acks); end
    fire = 0;
    cyc();
    checks++; if (c_act !== m_act_vec()) begin failures++; $display("FAIL cooldown_active got=%0h exp=%0h", c_act, m_act_vec()); end
    checks++; if (c_pos !== m_pos_vec()) begin failures++; $display("FAIL cooldown_pos got=%0h exp=%0h", c_pos, m_pos_vec()); end
  endtask

  task automatic test_fill();
    bit acked, got;
    int x, y, nacks;
    sel = 1;
    apply_reset(1, 0);
    for (int i = 0; i < N; i++) begin
      x = $urandom_range(0, 1023); y = $urandom_range(0, 400);
      fire_once(2, x, y, acked);
      checks++; if (acked !== 1'b1) begin failures++; $display("FAIL fill_ack%0d got=%b exp=1", i, acked); end
      void'(m_fire(x, y));
    end
    cyc();
    checks++; if (c_act !== 8'hFF || c_cnt !== 4'd8) begin
      failures++; $display("FAIL fill_full got=%0h/%0d exp=ff/8", c_act, c_cnt);
    end
    x = $urandom_range(0, 1023); y = $urandom_range(0, 400);
    fire = 1; fx = XW'(x); fy = YW'(y); nacks = 0;
    for (int i = 0; i < 5; i++) begin #3; if (c_ack) nacks++; cyc(); end
    hit_v = 1; hit_idx = 3'd3;
    #3; if (c_ack) nacks++;
    cyc();
    hit_v = 0; m_act[3] = 0;
    #3; got = c_ack;
    cyc();
    fire = 0;
    checks++; if (nacks != 0) begin failures++; $display("FAIL fill_ninth_held got=%0d exp=0", nacks); end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL fill_realloc_ack got=%b exp=1", got); end
    void'(m_fire(x, y));
    checks++; if (c_act !== 8'hFF) begin failures++; $display("FAIL fill_realloc_active got=%0h exp=ff", c_act); end
    checks++; if (c_pos !== m_pos_vec()) begin failures++; $display("FAIL fill_realloc_pos got=%0h exp=%0h", c_pos, m_pos_vec()); end
  endtask

  task automatic test_retire();
    bit acked;
    int bl;
    int ys [3] = '{476, 475, 477};
    sel = 0;
    apply_reset(0, 8);
    fire_once(1, 5, 3, acked); void'(m_fire(5, 3));
    do_tick(bl); m_tick(); cyc();
    checks++; if (c_act !== '0 || c_cnt !== '0) begin failures++; $display("FAIL retire_up got=%0h/%0d exp=0/0", c_act, c_cnt); end
    checks++; if (c_pos !== m_pos_vec()) begin failures++; $display("FAIL retire_up_pos got=%0h exp=%0h", c_pos, m_pos_vec()); end
    sel = 1;
    apply_reset(1, 0);
    for (int i = 0; i < 3; i++) begin
      fire_once(2, 40 + i, ys[i], acked); void'(m_fire(40 + i, ys[i]));
    end
    do_tick(bl); m_tick(); cyc();
    checks++; if (c_act !== m_act_vec()) begin failures++; $display("FAIL retire_down got=%0h exp=%0h", c_act, m_act_vec()); end
    checks++; if (c_pos !== m_pos_vec()) begin failures++; $display("FAIL retire_down_pos got=%0h exp=%0h", c_pos, m_pos_vec()); end
    checks++; if (c_cnt !== m_count()) begin failures++; $display("FAIL retire_down_count got=%0d exp=%0d", c_cnt, m_count()); end
    do_tick(bl); m_tick(); cyc();
    checks++; if (c_act !== '0) begin failures++; $display("FAIL retire_down_edge got=%0h exp=0", c_act); end
  endtask

  task automatic test_overrun();
    bit acked;
    int n;
    sel = 0;
    apply_reset(0, 8);
    fire_once(1, 100, 200, acked); void'(m_fire(100, 200));
    tick = 1; cyc(); tick = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!c_busy) break;
      n++;
      tick = (n == 3);
      cyc();
      tick = 0;
    end
    m_tick();
    checks++; if (n != N) begin failures++; $display("FAIL overrun_sweep_len got=%0d exp=%0d", n, N); end
    checks++; if (c_ovr !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", c_ovr); end
    checks++; if (c_pos !== m_pos_vec()) begin failures++; $display("FAIL overrun_pos got=%0h exp=%0h", c_pos, m_pos_vec()); end
    clr = 1; cyc(); clr = 0;
    for (int k = 0; k < N; k++) m_act[k] = 0;
    m_cd = 0;
    checks++; if (c_act !== '0 || c_ovr !== 1'b0 || c_busy !== 1'b0 || c_cnt !== '0) begin
      failures++; $display("FAIL clear_state got act=%0h ovr=%b busy=%b cnt=%0d exp=0", c_act, c_ovr, c_busy, c_cnt);
    end
    checks++; if (c_pos !== m_pos_vec()) begin failures++; $display("FAIL clear_pos_kept got=%0h exp=%0h", c_pos, m_pos_vec()); end
    fire_once(1, 7, 77, acked);
    checks++; if (acked !== 1'b1) begin failures++; $display("FAIL clear_cooldown got=%b exp=1", acked); end
  endtask

  task automatic test_hit_sweep_reset();
    bit acked;
    int n;
    sel = 1;
    apply_reset(1, 0);
    for (int i = 0; i < 3; i++) begin
      fire_once(2, 10 * i, 100 * (i + 1), acked); void'(m_fire(10 * i, 100 * (i + 1)));
    end
    tick = 1; cyc(); tick = 0;
    cyc();
    do_hit(1);
    m_tick();
    n = 2;
    while (c_busy && n < 40) begin n++; cyc(); end
    checks++; if (n != N) begin failures++; $display("FAIL hit_sweep_len got=%0d exp=%0d", n, N); end
    cyc();
    checks++; if (c_act !== m_act_vec()) begin failures++; $display("FAIL hit_sweep_active got=%0h exp=%0h", c_act, m_act_vec()); end
    checks++; if (c_pos !== m_pos_vec()) begin failures++; $display("FAIL hit_sweep_pos got=%0h exp=%0h", c_pos, m_pos_vec()); end
    checks++; if (c_cnt !== m_count()) begin failures++; $display("FAIL hit_sweep_count got=%0d exp=%0d", c_cnt, m_count()); end
    tick = 1; cyc(); tick = 0;
    cyc(); cyc();
    rst = 1; cyc(); rst = 0;
    checks++; if (c_busy !== 1'b0 || c_act !== '0 || c_pos !== '0 || c_cnt !== '0 || c_ovr !== 1'b0 || c_ack !== 1'b0) begin
      failures++; $display("FAIL midsweep_reset got busy=%b act=%0h cnt=%0d ovr=%b exp=0", c_busy, c_act, c_cnt, c_ovr);
    end
  endtask

  task automatic test_random(input int s);
    bit acked, exp;
    int op, x, y, bl;
    sel = s;
    apply_reset(s, (s != 0) ? 0 : 8);
    for (int it = 0; it < 50; it++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        x = $urandom_range(0, 1023); y = $urandom_range(0, 479);
        exp = (m_cd == 0) && (m_free() >= 0);
        fire_once(1, x, y, acked);
        checks++; if (acked !== exp) begin failures++; $display("FAIL rand%0d_ack it=%0d got=%b exp=%b", s, it, acked, exp); end
        if (acked) void'(m_fire(x, y));
      end else if (op < 8) begin
        do_tick(bl); m_tick();
        checks++; if (bl != N) begin failures++; $display("FAIL rand%0d_sweep it=%0d got=%0d exp=%0d", s, it, bl, N); end
      end else begin
        do_hit($urandom_range(0, N - 1));
      end
      cyc();
      checks++; if (c_act !== m_act_vec()) begin failures++; $display("FAIL rand%0d_active it=%0d got=%0h exp=%0h", s, it, c_act, m_act_vec()); end
      checks++; if (c_pos !== m_pos_vec()) begin failures++; $display("FAIL rand%0d_pos it=%0d got=%0h exp=%0h", s, it, c_pos, m_pos_vec()); end
      checks++; if (c_cnt !== m_count()) begin failures++; $display("FAIL rand%0d_count it=%0d got=%0d exp=%0d", s, it, c_cnt, m_count()); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 0;
    rst = 1; tick = 0; clr = 0; fire = 0; hit_v = 0; fx = '0; fy = '0; hit_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic_fire();
    test_cooldown();
    test_fill();
    test_retire();
    test_overrun();
    test_hit_sweep_reset();
    test_random(0);
    test_random(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
